// File: rtl/fifo_arb_pkg.sv
// Shared encodings, default sizes and reset constants for the FIFO arbiter controller.
package fifo_arb_pkg;

  localparam int unsigned NFifoDefault   = 4;
  localparam int unsigned DataWDefault   = 12;
  localparam int unsigned UmbralWDefault = 3;

  localparam logic [2:0] UmbralSupRst = 3'b110;
  localparam logic [2:0] UmbralInfRst = 3'b001;

  typedef enum logic [4:0] {
    StReset  = 5'b00001,
    StInit   = 5'b00010,
    StIdle   = 5'b00100,
    StActive = 5'b01000,
    StError  = 5'b10000
  } state_e;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fifo_arb_ctrl_rr_arbiter.sv
// One-hot grant from a request vector. Round-robin after last_granted_i by default;
// FIFO_ARB_FIXED_PRIO_EN selects fixed priority, lowest index first.
module rr_arbiter #(
  parameter int unsigned N    = 4,
  parameter int unsigned IdxW = 2
) (
  input  logic [N-1:0]    req_i,
  input  logic [IdxW-1:0] last_granted_i,
  output logic [N-1:0]    grant_o
);

  logic found;

`ifdef FIFO_ARB_FIXED_PRIO_EN
  logic unused_last_granted;
  assign unused_last_granted = ^last_granted_i;

  always_comb begin
    grant_o = '0;
    found   = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (!found && req_i[i]) begin
        grant_o[i] = 1'b1;
        found      = 1'b1;
      end
    end
  end
`else
  // Search offsets 1..N from the last winner, so the last winner is considered last.
  always_comb begin
    grant_o = '0;
    found   = 1'b0;
    for (int unsigned k = 1; k <= N; k++) begin
      for (int unsigned i = 0; i < N; i++) begin
        if (!found && req_i[i] && (((32'(last_granted_i) + k) % N) == i)) begin
          grant_o[i] = 1'b1;
          found      = 1'b1;
        end
      end
    end
  end
`endif

endmodule

// File: rtl/fifo_arb_ctrl.sv
// Arbitration controller draining N_FIFO source FIFOs into one output stream.
// Define FIFO_ARB_FIXED_PRIO_EN for fixed-priority arbitration instead of round-robin.
module fifo_arb_ctrl
  import fifo_arb_pkg::*;
#(
  parameter int unsigned N_FIFO   = NFifoDefault,
  parameter int unsigned DATA_W   = DataWDefault,
  parameter int unsigned UMBRAL_W = UmbralWDefault
) (
  input  logic                     clk,
  input  logic                     reset_L,
  input  logic                     init,
  input  logic [UMBRAL_W-1:0]      umbral_superior_in,
  input  logic [UMBRAL_W-1:0]      umbral_inferior_in,
  input  logic [N_FIFO-1:0]        fifo_empty,
  input  logic [N_FIFO-1:0]        fifo_error,
  input  logic [N_FIFO*DATA_W-1:0] fifo_data,
  input  logic                     down_almost_full,
  output logic [N_FIFO-1:0]        fifo_pop,
  output logic [UMBRAL_W-1:0]      umbral_superior,
  output logic [UMBRAL_W-1:0]      umbral_inferior,
  output logic [DATA_W-1:0]        data_out,
  output logic                     valid_out,
  output logic [4:0]               state,
  output logic                     idle,
  output logic [N_FIFO-1:0]        error_out
);

  localparam int unsigned IdxW = idx_width(N_FIFO);

  state_e              state_q, state_d;
  logic [UMBRAL_W-1:0] sup_q, sup_d, inf_q, inf_d;
  logic [N_FIFO-1:0]   error_q, error_d;
  logic [IdxW-1:0]     last_q, last_d;
  logic [IdxW-1:0]     pop_idx_q, pop_idx_d;
  logic                valid_q, valid_d;
  logic [N_FIFO-1:0]   req, grant;
  logic [IdxW-1:0]     grant_idx;

  // Pops depend on live inputs so backpressure takes effect in the same cycle.
  assign req = (state_q == StActive && !down_almost_full) ? ~fifo_empty : '0;

  rr_arbiter #(
    .N    (N_FIFO),
    .IdxW (IdxW)
  ) u_arb (
    .req_i          (req),
    .last_granted_i (last_q),
    .grant_o        (grant)
  );

  always_comb begin
    grant_idx = '0;
    for (int unsigned i = 0; i < N_FIFO; i++) begin
      if (grant[i]) grant_idx = IdxW'(i);
    end
  end

  always_comb begin
    state_d = state_q;
    if (state_q == StReset) begin
      state_d = StInit;
    end else if (|fifo_error) begin
      state_d = StError;
    end else if (init) begin
      state_d = StInit;
    end else begin
      unique case (state_q)
        StInit:   state_d = StIdle;
        StIdle:   if (!(&fifo_empty)) state_d = StActive;
        StActive: if (&fifo_empty) state_d = StIdle;
        default:  state_d = state_q;
      endcase
    end
  end

  always_comb begin
    sup_d     = sup_q;
    inf_d     = inf_q;
    if (state_q == StInit) begin
      sup_d = umbral_superior_in;
      inf_d = umbral_inferior_in;
    end
    error_d   = (state_q == StError && state_d == StInit) ? '0 : (error_q | fifo_error);
    last_d    = (|grant) ? grant_idx : last_q;
    pop_idx_d = grant_idx;
    valid_d   = |grant;
  end

  always_ff @(posedge clk) begin
    if (!reset_L) begin
      state_q   <= StReset;
      sup_q     <= UMBRAL_W'(UmbralSupRst);
      inf_q     <= UMBRAL_W'(UmbralInfRst);
      error_q   <= '0;
      last_q    <= IdxW'(N_FIFO - 1);
      pop_idx_q <= '0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      sup_q     <= sup_d;
      inf_q     <= inf_d;
      error_q   <= error_d;
      last_q    <= last_d;
      pop_idx_q <= pop_idx_d;
      valid_q   <= valid_d;
    end
  end

  // FIFO read data arrives the cycle after the pop, so the word is muxed from live inputs.
  always_comb begin
    data_out = '0;
    for (int unsigned i = 0; i < N_FIFO; i++) begin
      if (valid_q && pop_idx_q == IdxW'(i)) data_out = fifo_data[i*DATA_W +: DATA_W];
    end
  end

  assign fifo_pop        = grant;
  assign valid_out       = valid_q;
  assign state           = state_q;
  assign idle            = (state_q == StIdle);
  assign error_out       = error_q;
  assign umbral_superior = sup_q;
  assign umbral_inferior = inf_q;

endmodule

// File: tb/tb_fifo_arb_ctrl.sv
// Bench for fifo_arb_ctrl: directed vector table, hand sequences and random stimulus
// checked against a cycle-level reference model.
module tb_fifo_arb_ctrl;

  localparam int N  = 4;
  localparam int DW = 12;
  // Model states: 0 reset, 1 init, 2 idle, 3 active, 4 error; DUT encoding is 1 << index.
  localparam int MReset = 0, MInit = 1, MIdle = 2, MActive = 3, MError = 4;

  logic          clk = 1'b0;
  logic          reset_L, init, down_almost_full;
  logic [2:0]    umbral_superior_in, umbral_inferior_in, umbral_superior, umbral_inferior;
  logic [N-1:0]  fifo_empty, fifo_error, fifo_pop, error_out;
  logic [N*DW-1:0] fifo_data;
  logic [DW-1:0] data_out;
  logic          valid_out, idle;
  logic [4:0]    state;

  always #5 clk = ~clk;

  fifo_arb_ctrl dut (
    .clk                (clk),
    .reset_L            (reset_L),
    .init               (init),
    .umbral_superior_in (umbral_superior_in),
    .umbral_inferior_in (umbral_inferior_in),
    .fifo_empty         (fifo_empty),
    .fifo_error         (fifo_error),
    .fifo_data          (fifo_data),
    .down_almost_full   (down_almost_full),
    .fifo_pop           (fifo_pop),
    .umbral_superior    (umbral_superior),
    .umbral_inferior    (umbral_inferior),
    .data_out           (data_out),
    .valid_out          (valid_out),
    .state              (state),
    .idle               (idle),
    .error_out          (error_out)
  );

  int n_vec = 0;
  int n_bad = 0;

  int         m_st = 0, m_last = N - 1, m_pidx = 0;
  bit         m_known = 1'b0, m_pend = 1'b0;
  logic [3:0] m_err = '0;
  logic [2:0] m_sup = 3'd6, m_inf = 3'd1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Serve the first non-empty FIFO in search order; order starts after the last winner.
  function automatic logic [3:0] model_pop();
    logic [3:0] r;
    int first;
    r = '0;
`ifdef FIFO_ARB_FIXED_PRIO_EN
    first = 0;
`else
    first = m_last + 1;
`endif
    if (m_st == MActive && !down_almost_full) begin
      for (int k = 0; k < N; k++) begin
        int i = (first + k) % N;
        if (r == 4'h0 && !fifo_empty[i[1:0]]) r[i[1:0]] = 1'b1;
      end
    end
    return r;
  endfunction

  function automatic logic [DW-1:0] slice(input int i);
    return DW'(fifo_data >> (i * DW));
  endfunction

  // Called with inputs already applied just after a falling edge.
  task automatic tick();
    logic [3:0] ep;
    #1;
    ep = model_pop();
    if (m_known) begin
      check("m.state", 32'(state), 32'(1) << m_st);
      check("m.idle", 32'(idle), 32'(m_st == MIdle));
      check("m.pop", 32'(fifo_pop), 32'(ep));
      check("m.valid", 32'(valid_out), 32'(m_pend));
      check("m.data", 32'(data_out), m_pend ? 32'(slice(m_pidx)) : 32'd0);
      check("m.error_out", 32'(error_out), 32'(m_err));
      check("m.usup", 32'(umbral_superior), 32'(m_sup));
      check("m.uinf", 32'(umbral_inferior), 32'(m_inf));
    end
    @(posedge clk);
    if (!reset_L) begin
      m_known = 1'b1; m_st = MReset; m_last = N - 1; m_pend = 1'b0;
      m_err = '0; m_sup = 3'd6; m_inf = 3'd1;
    end else if (m_known) begin
      if (m_st == MInit) begin
        m_sup = umbral_superior_in;
        m_inf = umbral_inferior_in;
      end
      if (m_st == MError && fifo_error == 4'h0 && init) m_err = '0;
      else m_err = m_err | fifo_error;
      m_pend = (ep != 4'h0);
      for (int i = 0; i < N; i++) begin
        if (ep[i[1:0]]) begin m_last = i; m_pidx = i; end
      end
      if (m_st == MReset) m_st = MInit;
      else if (fifo_error != 4'h0) m_st = MError;
      else if (init) m_st = MInit;
      else if (m_st == MInit) m_st = MIdle;
      else if (m_st == MIdle && fifo_empty != 4'hF) m_st = MActive;
      else if (m_st == MActive && fifo_empty == 4'hF) m_st = MIdle;
    end
    @(negedge clk);
  endtask

  task automatic apply(input logic rst, input logic ini, input logic [3:0] emp,
                       input logic [3:0] er, input logic df);
    reset_L = rst; init = ini; fifo_empty = emp; fifo_error = er; down_almost_full = df;
  endtask

  typedef struct packed {
    logic rst; logic ini; logic [3:0] emp; logic [3:0] er; logic df;
    logic [4:0] st; logic [3:0] pop; logic vld; logic [11:0] dat; logic [3:0] eo;
    logic [2:0] sup; logic [2:0] inf;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic rst, input logic ini, input logic [3:0] emp,
                     input logic [3:0] er, input logic df, input logic [4:0] st,
                     input logic [3:0] pop, input logic vld, input logic [11:0] dat,
                     input logic [3:0] eo, input logic [2:0] sup, input logic [2:0] inf);
    vec_t v;
    v.rst = rst; v.ini = ini; v.emp = emp; v.er = er; v.df = df; v.st = st; v.pop = pop;
    v.vld = vld; v.dat = dat; v.eo = eo; v.sup = sup; v.inf = inf;
    tbl.push_back(v);
  endtask

  initial begin
    apply(1'b0, 1'b0, 4'hF, 4'h0, 1'b0);
    umbral_superior_in = 3'd5;
    umbral_inferior_in = 3'd2;
    fifo_data = {12'h004, 12'h003, 12'h002, 12'h001};
    @(negedge clk);
    tick();
    tick();

`ifndef FIFO_ARB_FIXED_PRIO_EN
    // rst ini emp   er    df  | state  pop   v  data    eo   sup   inf
    add(1, 1, 4'hF, 4'h0, 0, 5'h01, 4'h0, 0, 12'h000, 4'h0, 3'd6, 3'd1);
    add(1, 1, 4'hF, 4'h0, 0, 5'h02, 4'h0, 0, 12'h000, 4'h0, 3'd6, 3'd1);
    add(1, 0, 4'hF, 4'h0, 0, 5'h02, 4'h0, 0, 12'h000, 4'h0, 3'd5, 3'd2);
    add(1, 0, 4'hF, 4'h0, 0, 5'h04, 4'h0, 0, 12'h000, 4'h0, 3'd5, 3'd2);
    add(1, 0, 4'h0, 4'h0, 0, 5'h04, 4'h0, 0, 12'h000, 4'h0, 3'd5, 3'd2);
    add(1, 0, 4'h0, 4'h0, 0, 5'h08, 4'h1, 0, 12'h000, 4'h0, 3'd5, 3'd2);
    add(1, 0, 4'h0, 4'h0, 0, 5'h08, 4'h2, 1, 12'h001, 4'h0, 3'd5, 3'd2);
    add(1, 0, 4'h0, 4'h0, 0, 5'h08, 4'h4, 1, 12'h002, 4'h0, 3'd5, 3'd2);
    add(1, 0, 4'h0, 4'h0, 0, 5'h08, 4'h8, 1, 12'h003, 4'h0, 3'd5, 3'd2);
    add(1, 0, 4'h0, 4'h0, 0, 5'h08, 4'h1, 1, 12'h004, 4'h0, 3'd5, 3'd2);
    add(1, 0, 4'h0, 4'h0, 1, 5'h08, 4'h0, 1, 12'h001, 4'h0, 3'd5, 3'd2);
    add(1, 0, 4'h0, 4'h0, 1, 5'h08, 4'h0, 0, 12'h000, 4'h0, 3'd5, 3'd2);
    add(1, 0, 4'h0, 4'h0, 1, 5'h08, 4'h0, 0, 12'h000, 4'h0, 3'd5, 3'd2);
    add(1, 0, 4'h0, 4'h0, 0, 5'h08, 4'h2, 0, 12'h000, 4'h0, 3'd5, 3'd2);
    add(1, 0, 4'h0, 4'h0, 0, 5'h08, 4'h4, 1, 12'h002, 4'h0, 3'd5, 3'd2);
    add(1, 0, 4'h0, 4'h4, 0, 5'h08, 4'h8, 1, 12'h003, 4'h0, 3'd5, 3'd2);
    add(1, 0, 4'h0, 4'h0, 0, 5'h10, 4'h0, 1, 12'h004, 4'h4, 3'd5, 3'd2);
    add(1, 0, 4'h0, 4'h0, 0, 5'h10, 4'h0, 0, 12'h000, 4'h4, 3'd5, 3'd2);
    add(1, 1, 4'h0, 4'h0, 0, 5'h10, 4'h0, 0, 12'h000, 4'h4, 3'd5, 3'd2);
    add(1, 0, 4'h0, 4'h0, 0, 5'h02, 4'h0, 0, 12'h000, 4'h0, 3'd5, 3'd2);
    add(1, 0, 4'h0, 4'h0, 0, 5'h04, 4'h0, 0, 12'h000, 4'h0, 3'd5, 3'd2);
    add(1, 0, 4'hE, 4'h0, 0, 5'h08, 4'h1, 0, 12'h000, 4'h0, 3'd5, 3'd2);
    add(1, 0, 4'hF, 4'h0, 0, 5'h08, 4'h0, 1, 12'h001, 4'h0, 3'd5, 3'd2);
    add(1, 0, 4'hF, 4'h0, 0, 5'h04, 4'h0, 0, 12'h000, 4'h0, 3'd5, 3'd2);
    add(1, 0, 4'hE, 4'h0, 0, 5'h04, 4'h0, 0, 12'h000, 4'h0, 3'd5, 3'd2);
    add(0, 0, 4'hE, 4'h0, 0, 5'h08, 4'h1, 0, 12'h000, 4'h0, 3'd5, 3'd2);
    add(0, 0, 4'hE, 4'h0, 0, 5'h01, 4'h0, 0, 12'h000, 4'h0, 3'd6, 3'd1);
    foreach (tbl[r]) begin
      apply(tbl[r].rst, tbl[r].ini, tbl[r].emp, tbl[r].er, tbl[r].df);
      #1;
      check($sformatf("row%0d.state", r), 32'(state), 32'(tbl[r].st));
      check($sformatf("row%0d.pop", r), 32'(fifo_pop), 32'(tbl[r].pop));
      check($sformatf("row%0d.valid", r), 32'(valid_out), 32'(tbl[r].vld));
      check($sformatf("row%0d.data", r), 32'(data_out), 32'(tbl[r].dat));
      check($sformatf("row%0d.error_out", r), 32'(error_out), 32'(tbl[r].eo));
      check($sformatf("row%0d.usup", r), 32'(umbral_superior), 32'(tbl[r].sup));
      check($sformatf("row%0d.uinf", r), 32'(umbral_inferior), 32'(tbl[r].inf));
      tick();
    end
`endif

    // Reach ACTIVE, then check same-cycle backpressure and a pop on the last ACTIVE cycle.
    apply(1'b0, 1'b0, 4'h0, 4'h0, 1'b0); tick();
    apply(1'b1, 1'b0, 4'h0, 4'h0, 1'b0); tick();
    tick();
    tick();
    down_almost_full = 1'b1;
    #1 check("bp.pop_blocked", 32'(fifo_pop), 32'h0);
    down_almost_full = 1'b0;
    init = 1'b1;
    #1 check("last_active.pop", 32'(fifo_pop), 32'h1);
    tick();
    init = 1'b0;
    #1;
    check("last_active.state", 32'(state), 32'h02);
    check("last_active.valid", 32'(valid_out), 32'h1);
    check("last_active.data", 32'(data_out), 32'h001);
    check("last_active.pop0", 32'(fifo_pop), 32'h0);
    tick();

`ifdef FIFO_ARB_FIXED_PRIO_EN
    begin
      int c0, c2;
      logic [3:0] exp_pop;
      c0 = 2; c2 = 2;
      apply(1'b1, 1'b0, 4'b1010, 4'h0, 1'b0); tick();
      for (int k = 0; k < 4; k++) begin
        fifo_empty = {1'b1, c2 == 0, 1'b1, c0 == 0};
        exp_pop = (c0 > 0) ? 4'b0001 : 4'b0100;
        #1 check($sformatf("fixed.pop%0d", k), 32'(fifo_pop), 32'(exp_pop));
        tick();
        if (c0 > 0) c0--; else c2--;
      end
    end
`endif

    for (int c = 0; c < 1500; c++) begin
      reset_L            = ($urandom_range(63) != 0);
      init               = ($urandom_range(31) == 0);
      fifo_error         = ($urandom_range(39) == 0) ? 4'($urandom_range(15)) : 4'h0;
      down_almost_full   = ($urandom_range(3) == 0);
      fifo_empty         = 4'($urandom) & 4'($urandom);
      fifo_data          = 48'({$urandom, $urandom});
      umbral_superior_in = 3'($urandom);
      umbral_inferior_in = 3'($urandom);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/fifo_arb_ctrl.md
FIFO_ARB_CTRL -- requirements
Module: fifo_arb_ctrl

Interface
REQ-001 Parameters SHALL be: N_FIFO, 4, number of source FIFOs; DATA_W, 12, word width; UMBRAL_W, 3, threshold width.
REQ-002 Ports SHALL be:
- clk  in  1  single clock; all logic on its rising edge.
- reset_L  in  1  synchronous, active-low reset.
- init  in  1  request to enter or re-enter INIT.
- umbral_superior_in  in  UMBRAL_W  almost-full threshold to program.
- umbral_inferior_in  in  UMBRAL_W  almost-empty threshold to program.
- fifo_empty  in  N_FIFO  per-FIFO empty flag.
- fifo_error  in  N_FIFO  per-FIFO error pulse (push-on-full or pop-on-empty).
- fifo_data  in  N_FIFO*DATA_W  FIFO read data; slice i belongs to FIFO i; valid the cycle after its pop.
- down_almost_full  in  1  downstream backpressure.
- fifo_pop  out  N_FIFO  one-hot pop strobes.
- umbral_superior  out  UMBRAL_W  programmed threshold to all FIFOs.
- umbral_inferior  out  UMBRAL_W  programmed threshold to all FIFOs.
- data_out  out  DATA_W  arbitrated word.
- valid_out  out  1  data_out qualifier.
- state  out  5  one-hot FSM state.
- idle  out  1  high in IDLE.
- error_out  out  N_FIFO  sticky record of which FIFOs flagged an error.

Function
REQ-003 The FSM states SHALL be one-hot: RESET 00001, INIT 00010, IDLE 00100, ACTIVE 01000, ERROR 10000.
REQ-004 Transition priority SHALL be reset_L=0 > any fifo_error bit > init=1 > the normal transitions below.
REQ-005 RESET SHALL go to INIT on the first edge with reset_L=1.
REQ-006 INIT SHALL load umbral_superior/umbral_inferior from the *_in ports on every cycle it is occupied, and SHALL go to IDLE on the first cycle with init=0.
REQ-007 IDLE SHALL go to ACTIVE when any fifo_empty bit is 0.
REQ-008 ACTIVE SHALL go to IDLE when all fifo_empty bits are 1 and no pop is issued that cycle.
REQ-009 IDLE or ACTIVE SHALL go to INIT when init=1.
REQ-010 Any state except RESET SHALL go to ERROR when fifo_error is nonzero.
REQ-011 ERROR SHALL stay in ERROR until reset_L=0 or init=1; init=1 goes to INIT and clears error_out.
REQ-012 In each cycle, the OR of fifo_error SHALL be accumulated into error_out.
REQ-013 Pop rules:
- At most one fifo_pop bit SHALL be asserted per cycle.
- A pop SHALL be issued only when state=ACTIVE, down_almost_full=0, and the chosen FIFO has fifo_empty=0.
- The pop SHALL be combinational from these inputs, so backpressure stops pops in the same cycle.
REQ-014 Default arbitration SHALL be round-robin: search starts at (last_granted+1) mod N_FIFO; last_granted updates only on an issued pop; reset value of last_granted is N_FIFO-1, so FIFO0 is served first.
REQ-015 Output timing:
- One cycle after a pop of FIFO i, valid_out SHALL be 1 and data_out SHALL equal fifo_data slice i.
- Otherwise valid_out=0 and data_out=0.
- Pop-to-data_out latency SHALL be exactly 1 cycle.
REQ-016 Leaving ACTIVE for any reason SHALL suppress further pops immediately; a pop issued on the last ACTIVE cycle SHALL still produce its valid_out on the next cycle.
REQ-017 In INIT and ERROR, fifo_pop SHALL be 0.

Reset
REQ-018 With reset_L=0 at a clk edge, the following SHALL be set:
- state=RESET
- fifo_pop=0, valid_out=0, data_out=0
- umbral_superior=3'b110, umbral_inferior=3'b001
- error_out=0, idle=0
- last_granted=N_FIFO-1
REQ-019 Reset asserted mid-transfer SHALL discard a pending valid_out; no word SHALL appear after reset.

Configuration
REQ-020 With macro FIFO_ARB_FIXED_PRIO_EN defined, arbitration SHALL be fixed priority, lowest index first, and last_granted SHALL be unused.
REQ-021 Without FIFO_ARB_FIXED_PRIO_EN, arbitration SHALL be round-robin per REQ-014.

Structure
REQ-022 Package fifo_arb_pkg SHALL hold:
- state encodings
- N_FIFO, DATA_W, UMBRAL_W defaults
- reset threshold constants 3'b110 and 3'b001
REQ-023 Grant computation SHALL live in one sub-module, rr_arbiter, which takes a request vector and last_granted and returns a one-hot grant; REQ-020 is selected inside it.

Verification
REQ-024 Reset low 2 cycles, then init=1 with umbral_superior_in=5, umbral_inferior_in=2 for 2 cycles, then init=0 -> state path RESET->INIT->IDLE; thresholds read 5 and 2; no pops.
REQ-025 All four FIFOs non-empty with heads 0x001..0x004 -> pops on FIFO0,1,2,3,0 in consecutive cycles; data_out 0x001,0x002,0x003,0x004 each one cycle after its pop.
REQ-026 down_almost_full=1 for 3 cycles during ACTIVE -> fifo_pop=0 in exactly those cycles; the round-robin order resumes at the next FIFO after the last granted one.
REQ-027 fifo_error=4'b0100 while in ACTIVE -> state=ERROR next cycle; error_out=4'b0100; no pops until init=1, which returns to INIT and clears error_out.
REQ-028 Last FIFO drains (all empty after pop) -> valid_out for that word, then state=IDLE and idle=1; reset_L=0 in the same cycle as a pop -> valid_out stays 0.
REQ-029 With FIFO_ARB_FIXED_PRIO_EN defined and FIFO0 and FIFO2 non-empty -> FIFO0 is popped until empty before FIFO2.
